// File: rtl/drop_if.sv
// Signal bundle between the sensor front-end / display side and the drop sequencer.
// valid/ready: none; start is a level sampled only when the sequencer is idle (IDLE/DONE/FAULT).
interface drop_if;
   logic        start;
   logic [7:0]  sensor1;
   logic [7:0]  sensor2;
   logic [7:0]  sensor3;
   logic [7:0]  sensor4;
   logic [15:0] t_lim;
   logic        drop_en;
   logic        busy;
   logic        done;
   logic        fault;
   logic [7:0]  height;
   logic [15:0] t_act;
   logic        drop_activated;

   modport master (
      output start, sensor1, sensor2, sensor3, sensor4, t_lim, drop_en,
      input  busy, done, fault, height, t_act, drop_activated
   );

   modport slave (
      input  start, sensor1, sensor2, sensor3, sensor4, t_lim, drop_en,
      output busy, done, fault, height, t_act, drop_activated
   );
endinterface

// File: rtl/drop_sequencer.sv
// Baggage-drop sequencer: latch sensors, average, bit-serial sqrt, compare against
// the limit and drive a timed drop window. Every output is registered.
module drop_sequencer #(
   parameter int unsigned DROP_HOLD = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   drop_if.slave      bus,
   output logic [2:0] state_o
);

   localparam int unsigned HW = (DROP_HOLD < 2) ? 1 : $clog2(DROP_HOLD + 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SAMPLE = 3'd1,
      S_ROOT   = 3'd2,
      S_CMP    = 3'd3,
      S_DONE   = 3'd4,
      S_FAULT  = 3'd5
   } state_t;

   state_t         state_q, state_d;
   logic [7:0]     s1_q, s2_q, s3_q, s4_q;
   logic [15:0]    rad_q;
   logic [7:0]     root_q;
   logic [11:0]    rem_q;
   logic [2:0]     iter_q;
   logic [HW-1:0]  hold_q;
   logic           busy_q, done_q, fault_q, drop_q;
   logic [7:0]     height_q;
   logic [15:0]    t_act_q;

   logic           start_acc;
   logic           any_zero;
   logic [9:0]     sum;
   logic [11:0]    trial, test, diff;
   logic           ge;
   logic [15:0]    t_calc;

   assign start_acc = bus.start &&
                      (state_q == S_IDLE || state_q == S_DONE || state_q == S_FAULT);
   assign any_zero  = (s1_q == 8'd0) || (s2_q == 8'd0) || (s3_q == 8'd0) || (s4_q == 8'd0);
   assign sum       = {2'b00, s1_q} + {2'b00, s2_q} + {2'b00, s3_q} + {2'b00, s4_q};

   // Restoring sqrt step: bring down the next two radicand bits, try subtracting 4*root+1.
   assign trial  = (rem_q << 2) | {10'd0, rad_q[15:14]};
   assign test   = {2'b00, root_q, 2'b01};
   assign ge     = (trial >= test);
   assign diff   = trial - test;
   assign t_calc = 16'(root_q >> 1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE, S_FAULT: if (bus.start) state_d = S_SAMPLE;
         S_SAMPLE:                state_d = any_zero ? S_FAULT : S_ROOT;
         S_ROOT:                  if (iter_q == 3'd7) state_d = S_CMP;
         S_CMP:                   state_d = S_DONE;
         default:                 state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q     <= '0;
         s2_q     <= '0;
         s3_q     <= '0;
         s4_q     <= '0;
         rad_q    <= '0;
         root_q   <= '0;
         rem_q    <= '0;
         iter_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         fault_q  <= 1'b0;
         height_q <= '0;
         t_act_q  <= '0;
      end else begin
         done_q <= 1'b0;
         busy_q <= (state_d == S_SAMPLE) || (state_d == S_ROOT) || (state_d == S_CMP);
         case (state_q)
            S_IDLE, S_DONE, S_FAULT: begin
               if (start_acc) begin
                  s1_q    <= bus.sensor1;
                  s2_q    <= bus.sensor2;
                  s3_q    <= bus.sensor3;
                  s4_q    <= bus.sensor4;
                  fault_q <= 1'b0;
               end
            end
            S_SAMPLE: begin
               if (any_zero) begin
                  fault_q <= 1'b1;
                  done_q  <= 1'b1;
               end else begin
                  height_q <= 8'(sum >> 2);
                  rad_q    <= {8'(sum >> 2), 8'h00};
                  root_q   <= '0;
                  rem_q    <= '0;
                  iter_q   <= '0;
               end
            end
            S_ROOT: begin
               rem_q  <= ge ? diff : trial;
               root_q <= {root_q[6:0], ge};
               rad_q  <= rad_q << 2;
               iter_q <= iter_q + 3'd1;
            end
            S_CMP: begin
               t_act_q <= t_calc;
               done_q  <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Drop window: armed at the CMP->DONE edge, killed by drop_en low, timeout or a new start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_q <= 1'b0;
         hold_q <= '0;
      end else if (start_acc) begin
         drop_q <= 1'b0;
         hold_q <= '0;
      end else if (state_q == S_CMP) begin
         if (bus.drop_en && (t_calc <= bus.t_lim)) begin
            drop_q <= 1'b1;
            hold_q <= HW'(DROP_HOLD);
         end
      end else if (drop_q) begin
         if (!bus.drop_en || hold_q == HW'(1)) begin
            drop_q <= 1'b0;
            hold_q <= '0;
         end else begin
            hold_q <= hold_q - HW'(1);
         end
      end
   end

   assign bus.busy           = busy_q;
   assign bus.done           = done_q;
   assign bus.fault          = fault_q;
   assign bus.height         = height_q;
   assign bus.t_act          = t_act_q;
   assign bus.drop_activated = drop_q;
   assign state_o            = state_q;

endmodule

// File: tb/tb_drop_sequencer.sv
// Directed bench for drop_sequencer: vector table for measurement results plus
// hand-written sequences for the drop window, ignored starts and mid-sequence reset.
module tb_drop_sequencer;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam logic [2:0] ST_FAULT = 3'd5;

  logic       clk;
  logic       rst_n;
  logic [2:0] dbg_state;

  drop_if bus ();

  drop_sequencer #(.DROP_HOLD(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .state_o (dbg_state)
  );

  typedef struct {
    logic [7:0]  s1, s2, s3, s4;
    logic [15:0] t_lim;
    logic        en;
    logic [7:0]  h;
    logic [15:0] t;
    logic        drop;
    logic        fault;
  } vec_t;

  vec_t vecs[12];
  int   n_cmp = 0;
  int   n_err = 0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // drivers
  task automatic set_in(input logic [7:0] a, b, c, d, input logic [15:0] lim, input logic en);
    bus.sensor1 = a;
    bus.sensor2 = b;
    bus.sensor3 = c;
    bus.sensor4 = d;
    bus.t_lim   = lim;
    bus.drop_en = en;
  endtask

  task automatic start_pulse();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Counts negedges after the current one until done is seen; -1 on timeout.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int cnt;
    logic seen;

    vecs[0]  = '{8'd100, 8'd100, 8'd100, 8'd100, 16'd80,  1'b1, 8'd100, 16'd80,  1'b1, 1'b0};
    vecs[1]  = '{8'd100, 8'd100, 8'd100, 8'd100, 16'd79,  1'b1, 8'd100, 16'd80,  1'b0, 1'b0};
    vecs[2]  = '{8'd1,   8'd2,   8'd3,   8'd4,   16'd0,   1'b1, 8'd2,   16'd11,  1'b0, 1'b0};
    vecs[3]  = '{8'd255, 8'd255, 8'd255, 8'd255, 16'd127, 1'b1, 8'd255, 16'd127, 1'b1, 1'b0};
    vecs[4]  = '{8'd255, 8'd255, 8'd255, 8'd255, 16'd126, 1'b1, 8'd255, 16'd127, 1'b0, 1'b0};
    vecs[5]  = '{8'd1,   8'd1,   8'd1,   8'd1,   16'd8,   1'b0, 8'd1,   16'd8,   1'b0, 1'b0};
    vecs[6]  = '{8'd1,   8'd1,   8'd1,   8'd1,   16'd0,   1'b1, 8'd1,   16'd8,   1'b0, 1'b0};
    vecs[7]  = '{8'd1,   8'd1,   8'd1,   8'd1,   16'd8,   1'b1, 8'd1,   16'd8,   1'b1, 1'b0};
    vecs[8]  = '{8'd100, 8'd100, 8'd0,   8'd100, 16'd500, 1'b1, 8'd1,   16'd8,   1'b0, 1'b1};
    vecs[9]  = '{8'd10,  8'd20,  8'd30,  8'd41,  16'd40,  1'b1, 8'd25,  16'd40,  1'b1, 1'b0};
    vecs[10] = '{8'd200, 8'd100, 8'd50,  8'd3,   16'd100, 1'b1, 8'd88,  16'd75,  1'b1, 1'b0};
    vecs[11] = '{8'd0,   8'd5,   8'd5,   8'd5,   16'd500, 1'b1, 8'd88,  16'd75,  1'b0, 1'b1};

    rst_n     = 1'b0;
    bus.start = 1'b0;
    set_in(8'd0, 8'd0, 8'd0, 8'd0, 16'd0, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_state",  32'(dbg_state), 32'(ST_IDLE));
    chk("rst_busy",   32'(bus.busy), 0);
    chk("rst_done",   32'(bus.done), 0);
    chk("rst_fault",  32'(bus.fault), 0);
    chk("rst_height", 32'(bus.height), 0);
    chk("rst_t_act",  32'(bus.t_act), 0);
    chk("rst_drop",   32'(bus.drop_activated), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // table-driven measurements
    for (int i = 0; i < 12; i++) begin
      set_in(vecs[i].s1, vecs[i].s2, vecs[i].s3, vecs[i].s4, vecs[i].t_lim, vecs[i].en);
      start_pulse();
      wait_done(lat);
      chk($sformatf("v%0d_latency", i), 32'(lat), vecs[i].fault ? 32'd1 : 32'd10);
      chk($sformatf("v%0d_height", i),  32'(bus.height), 32'(vecs[i].h));
      chk($sformatf("v%0d_t_act", i),   32'(bus.t_act), 32'(vecs[i].t));
      chk($sformatf("v%0d_drop", i),    32'(bus.drop_activated), 32'(vecs[i].drop));
      chk($sformatf("v%0d_fault", i),   32'(bus.fault), 32'(vecs[i].fault));
      chk($sformatf("v%0d_busy", i),    32'(bus.busy), 0);
      chk($sformatf("v%0d_state", i),   32'(dbg_state), vecs[i].fault ? 32'(ST_FAULT) : 32'(ST_DONE));
      repeat (2) @(negedge clk);
    end

    // drop window lasts exactly 16 cycles; done is a single-cycle pulse
    set_in(8'd100, 8'd100, 8'd100, 8'd100, 16'd80, 1'b1);
    start_pulse();
    wait_done(lat);
    chk("win_latency", 32'(lat), 10);
    cnt = bus.drop_activated ? 1 : 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (k == 0) chk("done_width", 32'(bus.done), 0);
      if (bus.drop_activated) cnt++;
      else break;
    end
    chk("win_length", 32'(cnt), 16);

    // drop_en falling clears the window at the next edge
    start_pulse();
    wait_done(lat);
    repeat (3) @(negedge clk);
    chk("en_drop_before", 32'(bus.drop_activated), 1);
    bus.drop_en = 1'b0;
    @(negedge clk);
    chk("en_drop_after", 32'(bus.drop_activated), 0);

    // drop_en rising during ROOT still counts at the CMP edge
    set_in(8'd100, 8'd100, 8'd100, 8'd100, 16'd80, 1'b0);
    start_pulse();
    repeat (3) @(negedge clk);
    chk("root_busy", 32'(bus.busy), 1);
    bus.drop_en = 1'b1;
    wait_done(lat);
    chk("late_en_latency", 32'(lat + 3), 10);
    chk("late_en_drop", 32'(bus.drop_activated), 1);

    // start during ROOT (with new sensor values) is ignored
    set_in(8'd10, 8'd20, 8'd30, 8'd41, 16'd40, 1'b1);
    start_pulse();
    @(negedge clk);
    bus.start = 1'b1;
    set_in(8'd255, 8'd255, 8'd255, 8'd255, 16'd40, 1'b1);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(lat);
    chk("ign_latency", 32'(lat + 2), 10);
    chk("ign_height", 32'(bus.height), 25);
    chk("ign_t_act", 32'(bus.t_act), 40);
    @(negedge clk);
    chk("ign_state", 32'(dbg_state), 32'(ST_DONE));

    // reset at ROOT iteration 4: outputs clear at once, no done afterwards
    start_pulse();
    repeat (4) @(posedge clk);
    #1;
    chk("mid_busy_before", 32'(bus.busy), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_state",  32'(dbg_state), 32'(ST_IDLE));
    chk("mid_busy",   32'(bus.busy), 0);
    chk("mid_height", 32'(bus.height), 0);
    chk("mid_t_act",  32'(bus.t_act), 0);
    chk("mid_drop",   32'(bus.drop_activated), 0);
    chk("mid_fault",  32'(bus.fault), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    chk("mid_no_done", 32'(seen), 0);
    chk("mid_idle",    32'(dbg_state), 32'(ST_IDLE));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
